fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Synchronous first-word-fall-through FIFO.
- The write side steers each accepted word into one storage slot, demux-style. The read side selects the head slot onto `out`, mux-style.
- It sits between a producer and a consumer in the datapath and decouples them with valid/ready handshakes on both ends.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of storage slots. Must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width. This is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data.
- in_valid  input  1  producer has a word on `in`.
- in_ready  output  1  FIFO can accept a word this cycle.
- out  output  WIDTH  head-of-queue data.
- out_valid  output  1  `out` holds a valid word.
- out_ready  input  1  consumer takes `out` this cycle.
- count  output  PTR_W+1  number of words stored, 0..DEPTH.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low. While reset_n=0 the block holds: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out=0.
  - Storage contents are not reset.
  - Deassertion takes effect at the first rising clk edge after reset_n goes high.
- Handshake rules:
  - write = in_valid && in_ready
  - read = out_valid && out_ready
  - Both are evaluated at the rising edge of clk.
  - in_ready = (count != DEPTH). It is a combinational function of state only and never depends on in_valid or out_ready.
  - out_valid = (count != 0). out = storage[rd_ptr] when out_valid=1, otherwise 0. Both are combinational from state only.
- On a write: storage[wr_ptr] <= in; wr_ptr <= wr_ptr+1 modulo DEPTH.
- On a read: rd_ptr <= rd_ptr+1 modulo DEPTH.
- count update:
  - count+1 on write only.
  - count-1 on read only.
  - unchanged on both or neither.
- Latency: a word written at edge N is visible on out/out_valid after edge N (for reads at edge N+1) when the FIFO was empty. There is no combinational in-to-out bypass.
- Boundary cases:
  - Full (count=DEPTH): in_ready=0. in_valid is ignored and the storage is unmodified. A read in the same cycle frees one slot, but in_ready stays 0 until after that edge. There is no same-cycle write-on-full.
  - Empty (count=0): out_valid=0, out=0. out_ready is ignored and the pointers do not move.
  - Simultaneous write and read with 0<count<DEPTH: both take effect and count is unchanged. The written slot never equals the head slot, so there is no read/write collision.
  - Wrap-around: pointers wrap DEPTH-1 -> 0 silently. Ordering is strictly FIFO across the wrap.
  - Reset mid-operation: all queued words are discarded immediately (count=0, out_valid=0, out=0), regardless of clk.
- `in` is don't-care when in_valid=0. out_ready is don't-care when out_valid=0.
- No X may propagate to in_ready, out_valid, count, or out (while out_valid=0) after reset.

Test Plan:
- Reset check: assert reset_n=0 with no clk edges. Required: count===0, out_valid===0, in_ready===1, out===0.
- Single word, WIDTH=16, DEPTH=8:
  - Write 16'hA5A5 with out_ready=0. After the edge: out_valid===1, out===16'hA5A5, count===1.
  - Then pulse out_ready for one cycle. Required: out_valid===0, out===0, count===0.
- Fill and overflow:
  - Write 1..8 on consecutive edges. Required: in_ready===0 and count===8.
  - Drive in=16'hFFFF with in_valid=1 for 2 cycles, then drain. Required: exactly 1..8 come out in order, no 16'hFFFF appears, and count returns to 0.
- Wrap-around with simultaneous traffic:
  - Preload 3 words, then for 20 cycles write an incrementing value and read every cycle.
  - Required: count stays 3 and the read sequence equals the write sequence delayed by 3 words, through several pointer wraps.
- Backpressure: write 5 words, hold out_ready=0 for 4 cycles, then read. Required: out is stable at word 1 throughout the stall and the words drain in order.
- Reset mid-operation: with count=6, drop reset_n between clk edges. Required: count===0, out_valid===0, in_ready===1 immediately, with no edge needed. After release, the next written word is the first read out.

Source files
------------

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Writes are steered into one slot through a write-enable demux.
// The head slot is selected onto `out` through a read mux.
// Storage is not reset. Only the pointers and the occupancy count are.
module fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [DEPTH-1:0] slot_we;
    logic [WIDTH-1:0] head_data;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    // Handshake status is derived from the stored count only, so ready/valid never loop through the peer.
    always_comb begin
        full      = (count_q == DEPTH_CNT);
        empty     = (count_q == '0);
        in_ready  = !full;
        out_valid = !empty;
        wr_en     = in_valid && in_ready;
        rd_en     = out_valid && out_ready;
    end

    // Next pointer and occupancy values.
    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    // Reset discards every queued word immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write demux: exactly one slot enable is raised on an accepted write.
    always_comb begin
        slot_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_ptr_q == PTR_W'(i))) begin
                slot_we[i] = 1'b1;
            end
        end
    end

    // Storage slots capture `in` only when their enable is raised.
    // They are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                storage_q[i] <= in;
            end
        end
    end

    // Read mux picks the head slot.
    // The output is forced to zero while empty, so stale or unknown storage never leaks out.
    always_comb begin
        head_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr_q == PTR_W'(i)) begin
                head_data = storage_q[i];
            end
        end
        out   = out_valid ? head_data : '0;
        count = count_q;
    end

endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo (WIDTH=16, DEPTH=8).
// A vector table covers single-word, fill, overflow and drain behaviour.
// Hand-written sequences cover wrap-around, backpressure and asynchronous reset.
module tb_fifo;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        exp_ov;
        logic [15:0] exp_out;
        logic [3:0]  exp_cnt;
        logic        exp_ir;
    } vec_t;

    vec_t        vec_q[$];
    logic [15:0] model_q[$];

    fifo #(.WIDTH(16), .DEPTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add_vec(input logic iv, input logic [15:0] din, input logic ordy,
                                    input logic exp_ov, input logic [15:0] exp_out,
                                    input logic [3:0] exp_cnt, input logic exp_ir);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.exp_ov = exp_ov; v.exp_out = exp_out; v.exp_cnt = exp_cnt; v.exp_ir = exp_ir;
        vec_q.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then return 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic iv, input logic [15:0] din, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in        = din;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Same as apply_stimulus, but also keeps the reference queue in step with what the DUT should accept.
    task automatic model_step(input logic iv, input logic [15:0] din, input logic ordy);
        bit do_wr;
        bit do_rd;
        do_wr = iv && (model_q.size() < 8);
        do_rd = ordy && (model_q.size() > 0);
        apply_stimulus(iv, din, ordy);
        if (do_rd) void'(model_q.pop_front());
        if (do_wr) model_q.push_back(din);
    endtask

    initial begin
        // Vector table
        // single word in, then out, then a read attempt on an empty FIFO
        add_vec(1, 16'hA5A5, 0, 1, 16'hA5A5, 4'd1, 1);
        add_vec(0, 16'h0000, 1, 0, 16'h0000, 4'd0, 1);
        add_vec(0, 16'h0000, 1, 0, 16'h0000, 4'd0, 1);
        // fill with 1..8
        for (int k = 1; k <= 8; k++) begin
            add_vec(1, 16'(k), 0, 1, 16'd1, 4'(k), (k != 8));
        end
        // overflow attempts while full
        add_vec(1, 16'hFFFF, 0, 1, 16'd1, 4'd8, 0);
        add_vec(1, 16'hFFFF, 0, 1, 16'd1, 4'd8, 0);
        // read while full with in_valid still high: the write must be refused
        add_vec(1, 16'hFFFF, 1, 1, 16'd2, 4'd7, 1);
        // drain the rest; head after each read is k, count is 9-k
        for (int k = 3; k <= 9; k++) begin
            add_vec(0, 16'h0000, 1, (k <= 8), (k <= 8) ? 16'(k) : 16'h0000, 4'(9 - k), 1);
        end

        in        = 16'h0000;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b0;

        // Reset values, before any clock edge
        #2;
        check_output("reset_count",     32'(count),     32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_in_ready",  32'(in_ready),  32'd1);
        check_output("reset_out",       32'(out),       32'd0);

        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < vec_q.size(); i++) begin
            apply_stimulus(vec_q[i].iv, vec_q[i].din, vec_q[i].ordy);
            check_output($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec_q[i].exp_ov));
            check_output($sformatf("vec%0d_out", i),       32'(out),       32'(vec_q[i].exp_out));
            check_output($sformatf("vec%0d_count", i),     32'(count),     32'(vec_q[i].exp_cnt));
            check_output($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vec_q[i].exp_ir));
        end

        // Wrap-around with simultaneous traffic
        model_q.delete();
        for (int i = 0; i < 3; i++) begin
            model_step(1, 16'(16'h0100 + i), 0);
        end
        check_output("wrap_preload_count", 32'(count), 32'd3);
        for (int i = 0; i < 20; i++) begin
            model_step(1, 16'(16'h0103 + i), 1);
            check_output($sformatf("wrap%0d_count", i), 32'(count), 32'd3);
            check_output($sformatf("wrap%0d_out", i),   32'(out),   32'(16'(16'h0101 + i)));
        end
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("wrap_drain%0d_out", i), 32'(out), 32'(model_q[0]));
            model_step(0, 16'h0000, 1);
        end
        check_output("wrap_empty_count", 32'(count), 32'd0);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 16'(16'h0200 + i), 0);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 16'h0000, 0);
            check_output($sformatf("stall%0d_out", i),   32'(out),   32'h0200);
            check_output($sformatf("stall%0d_count", i), 32'(count), 32'd5);
        end
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp_drain%0d_out", i), 32'(out), 32'(16'(16'h0200 + i)));
            apply_stimulus(0, 16'h0000, 1);
        end
        check_output("bp_empty_valid", 32'(out_valid), 32'd0);

        // Reset mid-operation, applied between clock edges
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1, 16'(16'h0300 + i), 0);
        end
        in_valid = 1'b0;
        check_output("prereset_count", 32'(count), 32'd6);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("midreset_count",     32'(count),     32'd0);
        check_output("midreset_out_valid", 32'(out_valid), 32'd0);
        check_output("midreset_in_ready",  32'(in_ready),  32'd1);
        check_output("midreset_out",       32'(out),       32'd0);
        #1;
        reset_n = 1'b1;
        apply_stimulus(1, 16'h1234, 0);
        apply_stimulus(1, 16'h5678, 0);
        check_output("postreset_out",   32'(out),   32'h1234);
        check_output("postreset_count", 32'(count), 32'd2);
        apply_stimulus(0, 16'h0000, 1);
        check_output("postreset_next_out", 32'(out), 32'h5678);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
